// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
//   - Opcode encodings for the two-operand bitwise logic unit
//     (six functions plus two reserved codes).
//   - FSM state encoding used by the arbiter/sequencer.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_RSV6 = 3'd6;
    localparam logic [2:0] OP_RSV7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational two-operand bitwise logic unit.
// Ports:
//   op_i     [2:0]        opcode (see logic_op_pkg)
//   a_i      [WIDTH-1:0]  operand A
//   b_i      [WIDTH-1:0]  operand B
//   result_o [WIDTH-1:0]  bitwise result, zero for reserved opcodes
//   err_o                 high when the opcode is reserved
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    // Opcode-selected bitwise function; reserved codes flag an error.
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_RSV6, OP_RSV7: begin
                result_o = '0;
                err_o    = 1'b1;
            end
            default: begin
                result_o = '0;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one logic_unit among NREQ requesters.
// One request is in flight at a time: accept (IDLE) -> compute (EXEC) ->
// hold response until consumed (RESP).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid [NREQ]       per-requester request valid
//   req_ready [NREQ]       one-hot accept, combinational, only in IDLE
//   req_op    [3*NREQ]     opcodes, requester i at [3i +: 3]
//   req_a/b   [WIDTH*NREQ] operands, requester i at [WIDTH*i +: WIDTH]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/rsp_data/rsp_err registered response fields
//   busy                   high whenever the FSM is not in IDLE
module logic_unit_arbiter
    import logic_op_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    // One extra bit so (rr_ptr + k) can be wrapped without overflow.
    localparam int CW = IDW + 1;

    state_e           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic             any_valid_s;
    logic [IDW-1:0]   grant_id_s;
    logic [CW-1:0]    cand_s;
    logic [NREQ-1:0]  req_ready_s;
    logic [IDW-1:0]   rr_next_s;
    logic [2:0]       op_arr_s [NREQ];
    logic [WIDTH-1:0] a_arr_s  [NREQ];
    logic [WIDTH-1:0] b_arr_s  [NREQ];
    logic [WIDTH-1:0] lu_result_s;
    logic             lu_err_s;

    assign any_valid_s = |req_valid;

    // Round-robin pick: scan from rr_ptr upward with wrap. Iterating k from
    // the far end down lets the closest valid requester win the last write.
    always_comb begin
        grant_id_s = '0;
        cand_s     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, rr_ptr_q} + CW'(k);
            cand_s = (cand_s >= CW'(NREQ)) ? (cand_s - CW'(NREQ)) : cand_s;
            grant_id_s = req_valid[cand_s[IDW-1:0]] ? cand_s[IDW-1:0] : grant_id_s;
        end
    end

    // Unpack the flat request buses so the winner's fields are a plain index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr_s[i] = req_op[3*i +: 3];
            a_arr_s[i]  = req_a[WIDTH*i +: WIDTH];
            b_arr_s[i]  = req_b[WIDTH*i +: WIDTH];
        end
    end

    // Accept strobe; gated by rst_n so nothing is granted while held in reset.
    always_comb begin
        req_ready_s = '0;
        if (rst_n && (state_q == IDLE) && any_valid_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign rr_next_s = (id_q == IDW'(NREQ - 1)) ? '0 : (id_q + IDW'(1));

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (lu_result_s),
        .err_o    (lu_err_s)
    );

    // Sequencer FSM with issue and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid_s) begin
                        op_q    <= op_arr_s[grant_id_s];
                        a_q     <= a_arr_s[grant_id_s];
                        b_q     <= b_arr_s[grant_id_s];
                        id_q    <= grant_id_s;
                        state_q <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= lu_result_s;
                    rsp_err_q   <= lu_err_s;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    rr_ptr_q    <= rr_next_s;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit two-operand logic unit (AND/OR/NAND/NOR/XOR/XNOR) among NREQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The arbiter grants one request at a time, executes it in the shared unit, and returns a registered result tagged with the requester index. It sits between the client blocks and the basic-gate datapath as that datapath's sole owner.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(NREQ), derived requester-index width (localparam)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_op  in  3*NREQ  opcode, requester i at [3i+2:3i]
- req_a  in  WIDTH*NREQ  operand A, requester i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*NREQ  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_data  out  WIDTH  result
- rsp_err  out  1  opcode was reserved
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, all bitwise. Opcodes 6 and 7 are reserved: rsp_data = 0 and rsp_err = 1.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise select a winner by round-robin, searching upward from rr_ptr with wrap.
  - Drive req_ready[winner]=1 combinationally in the same cycle.
  - Latch op, a, b and the winner index into the issue register. Go to EXEC.
- EXEC:
  - Register the logic unit output into rsp_data, rsp_err and rsp_id.
  - Set rr_ptr = (winner+1) mod NREQ. Go to RESP.
- RESP:
  - rsp_valid=1 and the response outputs are held stable.
  - When rsp_ready=1, go to IDLE. Otherwise stay in RESP.
- req_ready is 0 in EXEC and RESP. No new request is accepted until the response handshake completes.
- A requester that drops req_valid before being granted loses its turn with no side effects.
- Request fields are sampled only in the accept cycle. Changes afterwards have no effect.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, and all of rsp_valid, rsp_id, rsp_data, rsp_err, busy and req_ready are 0.
- Latency: accept at cycle T, rsp_valid is high from T+2. The earliest next accept is T+3 when rsp_ready is already high. Peak throughput is one op per 3 cycles.
- Asserting rst_n low mid-operation aborts immediately: the pending result is discarded and rsp_valid drops asynchronously.
- Round-robin wrap: after a grant to NREQ-1, requester 0 has the highest priority.
- With all requesters valid continuously, grants occur in order 0,1,2,...,NREQ-1,0.
- busy equals (state != IDLE).

## Structure
- Package logic_op_pkg holds the opcode constants (OP_AND..OP_XNOR, reserved 6/7) and the FSM state enum (IDLE, EXEC, RESP).
- Sub-module logic_unit is purely combinational. It takes op, a and b and produces result and err as a mux over the six bitwise functions. It is instantiated once inside the arbiter.
- The arbiter contains the FSM, rr_ptr, the issue register and the response register.

## Test plan
- Reset: hold rst_n=0 with req_valid=4'b1111. Require all outputs 0. After release, requester 0 is granted first.
- Single op sweep: requester 2 sends a=8'hC3, b=8'hA5 for ops 0..5. Require data 81/E7/7E/18/66/99 respectively, with rsp_id=2 and rsp_err=0, each valid 2 cycles after accept.
- Reserved op: op=6 with a=8'hFF, b=8'hFF. Require rsp_data=0, rsp_err=1, and the FSM returns to IDLE.
- Fairness: all four requesters valid continuously with rsp_ready=1. Require the grant sequence 0,1,2,3,0,1 and exactly one req_ready bit per accept.
- Backpressure: hold rsp_ready=0 for 5 cycles. Require rsp_valid, rsp_id and rsp_data stable and req_ready=0 throughout. Release, and the next accept occurs in the following cycle.
- Mid-operation reset: pull rst_n low in EXEC and in RESP. Require rsp_valid=0 immediately. After release, no stale response appears.
